// File: rtl/temp_avg_display_if.sv
// Request/result bundle between the sensor accumulator and temp_avg_display.
// The accumulator side uses the master modport; the display stage uses the slave modport.
interface temp_avg_display_if #(
    parameter int unsigned SUM_W = 16,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned BAR_W = 8
);
    logic             start_i;
    logic [SUM_W-1:0] temp_sum_i;
    logic [CNT_W-1:0] active_sensors_nr_i;
    logic             alert_clr_i;
    logic             busy_o;
    logic             done_o;
    logic [SUM_W-1:0] avg_o;
    logic [BAR_W-1:0] coded_out_o;
    logic             alert_o;
    logic             err_o;

    modport master (
        output start_i, temp_sum_i, active_sensors_nr_i, alert_clr_i,
        input  busy_o, done_o, avg_o, coded_out_o, alert_o, err_o
    );

    modport slave (
        input  start_i, temp_sum_i, active_sensors_nr_i, alert_clr_i,
        output busy_o, done_o, avg_o, coded_out_o, alert_o, err_o
    );
endinterface

// File: rtl/temp_avg_display.sv
// Sequential average/thermometer stage: restoring divide, round-to-nearest, bar code, debounced alert.
// Optional macro TEMP_ALERT_LATCH_EN makes alert_o sticky until alert_clr_i.
module temp_avg_display #(
    parameter int unsigned SUM_W     = 16,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned BAR_W     = 8,
    parameter int unsigned T_MIN     = 19,
    parameter int unsigned ALERT_CNT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    temp_avg_display_if.slave     bus
);
    localparam int unsigned T_MAX  = T_MIN + BAR_W - 1;
    localparam int unsigned AC_W   = $clog2(ALERT_CNT + 1);
    localparam int unsigned STEP_W = $clog2(SUM_W);

    typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dvs_q, dvs_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SUM_W-1:0] avg_q, avg_d;
    logic [BAR_W-1:0] coded_q, coded_d;
    logic             alert_q, alert_d;
    logic             err_q, err_d;
    logic [AC_W-1:0]  oor_cnt_q, oor_cnt_d;

    logic [CNT_W:0]   rem_sh, trial, rem2;
    logic             fits, round_up, oor;
    logic [SUM_W:0]   avg_ext;
    logic [SUM_W-1:0] avg_sat, d_off;
    logic [BAR_W-1:0] coded_v;
    logic [AC_W-1:0]  cnt_step;

    always_comb begin
        // Quotient bits shift into quo_q as dividend bits shift out of its MSB.
        rem_sh   = {rem_q, quo_q[SUM_W-1]};
        fits     = rem_sh >= {1'b0, dvs_q};
        trial    = rem_sh - {1'b0, dvs_q};
        rem2     = {rem_q, 1'b0};
        round_up = rem2 >= {1'b0, dvs_q};
        avg_ext  = {1'b0, quo_q} + {{SUM_W{1'b0}}, round_up};
        avg_sat  = avg_ext[SUM_W] ? '1 : avg_ext[SUM_W-1:0];
        d_off    = avg_sat - SUM_W'(T_MIN);
        coded_v  = '0;
        oor      = 1'b0;
        if (avg_sat < SUM_W'(T_MIN)) begin
            coded_v = BAR_W'(1);
            oor     = 1'b1;
        end else if (avg_sat > SUM_W'(T_MAX)) begin
            coded_v = '1;
            oor     = 1'b1;
        end else begin
            for (int unsigned i = 0; i < BAR_W; i++) begin
                coded_v[i] = (SUM_W'(i) <= d_off);
            end
        end
        if (!oor)
            cnt_step = '0;
        else if (oor_cnt_q == AC_W'(ALERT_CNT))
            cnt_step = oor_cnt_q;
        else
            cnt_step = oor_cnt_q + AC_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        step_d    = step_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        avg_d     = avg_q;
        coded_d   = coded_q;
        alert_d   = alert_q;
        err_d     = err_q;
        oor_cnt_d = oor_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    quo_d   = bus.temp_sum_i;
                    dvs_d   = bus.active_sensors_nr_i;
                    rem_d   = '0;
                    step_d  = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    zero_d  = (bus.active_sensors_nr_i == '0);
                    state_d = (bus.active_sensors_nr_i == '0) ? FIN : DIV;
                end
            end
            DIV: begin
                quo_d  = {quo_q[SUM_W-2:0], fits};
                rem_d  = fits ? trial[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(SUM_W - 1))
                    state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = zero_q;
                state_d = IDLE;
                if (!zero_q) begin
                    avg_d     = avg_sat;
                    coded_d   = coded_v;
                    oor_cnt_d = cnt_step;
`ifdef TEMP_ALERT_LATCH_EN
                    alert_d   = alert_q | (cnt_step == AC_W'(ALERT_CNT));
`else
                    alert_d   = (cnt_step == AC_W'(ALERT_CNT));
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TEMP_ALERT_LATCH_EN
        // Clear overrides any same-edge qualifying result.
        if (bus.alert_clr_i) begin
            alert_d   = 1'b0;
            oor_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            step_q    <= '0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            avg_q     <= '0;
            coded_q   <= '0;
            alert_q   <= 1'b0;
            err_q     <= 1'b0;
            oor_cnt_q <= '0;
        end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            step_q    <= step_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            avg_q     <= avg_d;
            coded_q   <= coded_d;
            alert_q   <= alert_d;
            err_q     <= err_d;
            oor_cnt_q <= oor_cnt_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.avg_o       = avg_q;
    assign bus.coded_out_o = coded_q;
    assign bus.alert_o     = alert_q;
    assign bus.err_o       = err_q;
endmodule
